// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle main control unit for the RV32I core. Every instruction is
//   sequenced through FETCH/DECODE/EXEC/MEM/WB, with a handshake to a
//   variable-latency memory through mem_ready.
//
//   Optional feature macro: MCTRL_ILLEGAL_TRAP_EN
//     defined   : an illegal opcode sets the sticky 'illegal' flag and halts in TRAP
//     undefined : an illegal opcode retires as a NOP straight from DECODE
//
//   Parameters
//     ALUOP_W      width of ALUop (>= 3, bits above 2 are always zero)
//     MEM_TIMEOUT  wait cycles tolerated on mem_ready before trapping (0 = off)
//     CNT_W        width of the retired-instruction counter
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     instr        opcode field, sampled only in DECODE
//     mem_ready    memory completes the current fetch/load/store this cycle
//     pc_write .. jump   datapath controls
//     ALUop        ALU operation class
//     state        current state (debug)
//     retire       one-cycle pulse per completed instruction
//     instret      retired-instruction count, wraps
//     illegal      sticky illegal-opcode flag
//     mem_timeout  sticky memory-timeout flag
//
//   state   | meaning
//   --------+-----------------------------------------------
//   FETCH   | read instruction memory, wait for mem_ready
//   DECODE  | latch opcode class
//   EXEC    | ALU operation / branch resolve
//   MEM     | data load or store, wait for mem_ready
//   WB      | register file write-back
//   TRAP    | halted until reset

module multicycle_control #(
   parameter int ALUOP_W     = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         instr,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               branch,
   output logic               memread,
   output logic               memtoreg,
   output logic               memwrite,
   output logic               ALUsrc,
   output logic               regwrite,
   output logic               jump,
   output logic [ALUOP_W-1:0] ALUop,
   output logic [2:0]         state,
   output logic               retire,
   output logic [CNT_W-1:0]   instret,
   output logic               illegal,
   output logic               mem_timeout
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_NONE, C_R, C_LOAD, C_STORE, C_BRANCH, C_IMM, C_JALR, C_JAL, C_LUI, C_AUIPC
   } cls_t;

   state_t            state_q, state_nx;
   cls_t              cls_q, cls_nx, dec_cls;
   logic [WAIT_W-1:0] wait_q, wait_nx;
   logic              wait_hit;
   logic              set_illegal, set_timeout;

   logic pc_write_c, ir_write_c, branch_c, memread_c, memtoreg_c;
   logic memwrite_c, alusrc_c, regwrite_c, jump_c, retire_c;
   logic [2:0] aluop_c;

   always_comb begin
      case (instr)
         7'b0110011: dec_cls = C_R;
         7'b0000011: dec_cls = C_LOAD;
         7'b0100011: dec_cls = C_STORE;
         7'b1100011: dec_cls = C_BRANCH;
         7'b0010011: dec_cls = C_IMM;
         7'b1100111: dec_cls = C_JALR;
         7'b1101111: dec_cls = C_JAL;
         7'b0110111: dec_cls = C_LUI;
         7'b0010111: dec_cls = C_AUIPC;
         default:    dec_cls = C_NONE;
      endcase
   end

   // Trap fires on the wait cycle that would bring the count to the limit;
   // mem_ready on that same cycle takes priority because it is required low.
   assign wait_hit = (MEM_TIMEOUT != 0) && !mem_ready
                     && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_nx    = state_q;
      cls_nx      = cls_q;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      branch_c    = 1'b0;
      memread_c   = 1'b0;
      memtoreg_c  = 1'b0;
      memwrite_c  = 1'b0;
      alusrc_c    = 1'b0;
      regwrite_c  = 1'b0;
      jump_c      = 1'b0;
      retire_c    = 1'b0;
      aluop_c     = 3'b000;
      case (state_q)
         S_FETCH: begin
            memread_c = 1'b1;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_nx   = S_DECODE;
            end else if (wait_hit) begin
               set_timeout = 1'b1;
               state_nx    = S_TRAP;
            end
         end
         S_DECODE: begin
            cls_nx = dec_cls;
            if (dec_cls == C_NONE) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
               set_illegal = 1'b1;
               state_nx    = S_TRAP;
`else
               retire_c = 1'b1;
               state_nx = S_FETCH;
`endif
            end else begin
               state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            state_nx = S_WB;
            case (cls_q)
               C_R: aluop_c = 3'b010;
               C_IMM: begin
                  alusrc_c = 1'b1;
                  aluop_c  = 3'b011;
               end
               C_LOAD, C_STORE: begin
                  alusrc_c = 1'b1;
                  state_nx = S_MEM;
               end
               C_BRANCH: begin
                  branch_c = 1'b1;
                  aluop_c  = 3'b001;
                  retire_c = 1'b1;
                  state_nx = S_FETCH;
               end
               C_JAL, C_JALR: begin
                  jump_c   = 1'b1;
                  alusrc_c = 1'b1;
               end
               C_LUI: begin
                  alusrc_c = 1'b1;
                  aluop_c  = 3'b100;
               end
               C_AUIPC: alusrc_c = 1'b1;
               default: state_nx = S_FETCH;
            endcase
         end
         S_MEM: begin
            memread_c  = (cls_q == C_LOAD);
            memwrite_c = (cls_q != C_LOAD);
            if (mem_ready) begin
               if (cls_q == C_LOAD) begin
                  state_nx = S_WB;
               end else begin
                  retire_c = 1'b1;
                  state_nx = S_FETCH;
               end
            end else if (wait_hit) begin
               set_timeout = 1'b1;
               state_nx    = S_TRAP;
            end
         end
         S_WB: begin
            regwrite_c = 1'b1;
            memtoreg_c = (cls_q == C_LOAD);
            retire_c   = 1'b1;
            state_nx   = S_FETCH;
         end
         S_TRAP: state_nx = S_TRAP;
         default: state_nx = S_FETCH;
      endcase
   end

   // Counter runs only while parked in FETCH or MEM; any state change clears it.
   always_comb begin
      wait_nx = '0;
      if ((state_nx == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
         wait_nx = wait_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_FETCH;
         cls_q       <= C_NONE;
         wait_q      <= '0;
         instret     <= '0;
         illegal     <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state_q <= state_nx;
         cls_q   <= cls_nx;
         wait_q  <= wait_nx;
         if (retire_c)
            instret <= instret + 1'b1;
         if (set_illegal)
            illegal <= 1'b1;
         if (set_timeout)
            mem_timeout <= 1'b1;
      end
   end

   // Gate with rst so FETCH's memread does not leak out while reset is held.
   assign pc_write = rst & pc_write_c;
   assign ir_write = rst & ir_write_c;
   assign branch   = rst & branch_c;
   assign memread  = rst & memread_c;
   assign memtoreg = rst & memtoreg_c;
   assign memwrite = rst & memwrite_c;
   assign ALUsrc   = rst & alusrc_c;
   assign regwrite = rst & regwrite_c;
   assign jump     = rst & jump_c;
   assign retire   = rst & retire_c;
   assign ALUop    = rst ? ALUOP_W'(aluop_c) : '0;
   assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. A per-instruction reference expands each
// opcode plus chosen memory wait counts into the expected per-cycle trace.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] instr;
   logic       mem_ready;
   logic       pc_write, ir_write, branch, memread, memtoreg, memwrite;
   logic       ALUsrc, regwrite, jump, retire, illegal, mem_timeout;
   logic [3:0] ALUop;
   logic [2:0] state;
   logic [3:0] instret;

   multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(16), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .branch(branch),
      .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite),
      .ALUsrc(ALUsrc), .regwrite(regwrite), .jump(jump), .ALUop(ALUop),
      .state(state), .retire(retire), .instret(instret),
      .illegal(illegal), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   localparam logic [9:0] PCW = 10'h200, IRW = 10'h100, BR = 10'h080, MRD = 10'h040,
                          MTR = 10'h020, MWR = 10'h010, ASRC = 10'h008, RW = 10'h004,
                          JMP = 10'h002, RET = 10'h001;

   localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                          OP_BR = 7'b1100011, OP_IMM = 7'b0010011, OP_JALR = 7'b1100111,
                          OP_JAL = 7'b1101111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                          OP_BAD = 7'b1111111;

   typedef struct {
      logic [2:0] st;
      logic [9:0] ctrl;
      logic [3:0] aop;
      logic       mr;
      logic [6:0] opc;
      logic       ill;
      logic       mto;
   } exp_t;

   exp_t       q[$];
   logic [3:0] exp_instret;
   int         n_checks = 0;
   int         n_pass = 0;
   logic [6:0] legal_ops[9];

   wire [9:0] dut_ctrl = {pc_write, ir_write, branch, memread, memtoreg,
                          memwrite, ALUsrc, regwrite, jump, retire};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   task automatic push(input logic [2:0] st, input logic [9:0] ctrl, input logic [3:0] aop,
                       input logic mr, input logic [6:0] opc, input logic ill, input logic mto);
      exp_t e;
      e.st = st; e.ctrl = ctrl; e.aop = aop; e.mr = mr; e.opc = opc; e.ill = ill; e.mto = mto;
      q.push_back(e);
   endtask

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   function automatic logic [6:0] junk();
      return 7'($urandom);
   endfunction

   task automatic push_trap(input logic ill, input logic mto);
      for (int i = 0; i < 4; i++) push(3'd5, 10'h0, 4'd0, rbit(), junk(), ill, mto);
   endtask

   task automatic push_wb(input logic [9:0] extra);
      push(3'd4, RW | RET | extra, 4'd0, rbit(), junk(), 1'b0, 1'b0);
   endtask

   // Expected trace of one instruction: fw wait cycles in FETCH, mw in MEM.
   // A wait count of 16 or more reaches the timeout and ends in TRAP.
   task automatic expand(input logic [6:0] opc, input int fw, input int mw);
      bit legal;
      legal = 1'b0;
      foreach (legal_ops[i]) if (legal_ops[i] == opc) legal = 1'b1;
      for (int i = 0; i < ((fw < 16) ? fw : 16); i++)
         push(3'd0, MRD, 4'd0, 1'b0, junk(), 1'b0, 1'b0);
      if (fw >= 16) begin
         push_trap(1'b0, 1'b1);
         return;
      end
      push(3'd0, MRD | IRW | PCW, 4'd0, 1'b1, junk(), 1'b0, 1'b0);
      if (!legal) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
         push(3'd1, 10'h0, 4'd0, rbit(), opc, 1'b0, 1'b0);
         push_trap(1'b1, 1'b0);
`else
         push(3'd1, RET, 4'd0, rbit(), opc, 1'b0, 1'b0);
`endif
         return;
      end
      push(3'd1, 10'h0, 4'd0, rbit(), opc, 1'b0, 1'b0);
      case (opc)
         OP_R:   begin push(3'd2, 10'h0, 4'd2, rbit(), junk(), 0, 0); push_wb(10'h0); end
         OP_IMM: begin push(3'd2, ASRC, 4'd3, rbit(), junk(), 0, 0); push_wb(10'h0); end
         OP_LUI: begin push(3'd2, ASRC, 4'd4, rbit(), junk(), 0, 0); push_wb(10'h0); end
         OP_AUIPC: begin push(3'd2, ASRC, 4'd0, rbit(), junk(), 0, 0); push_wb(10'h0); end
         OP_JAL, OP_JALR: begin
            push(3'd2, JMP | ASRC, 4'd0, rbit(), junk(), 0, 0); push_wb(10'h0);
         end
         OP_BR: push(3'd2, BR | RET, 4'd1, rbit(), junk(), 0, 0);
         default: begin
            logic [9:0] mc;
            mc = (opc == OP_LOAD) ? MRD : MWR;
            push(3'd2, ASRC, 4'd0, rbit(), junk(), 0, 0);
            for (int i = 0; i < ((mw < 16) ? mw : 16); i++)
               push(3'd3, mc, 4'd0, 1'b0, junk(), 0, 0);
            if (mw >= 16) begin
               push_trap(1'b0, 1'b1);
            end else if (opc == OP_LOAD) begin
               push(3'd3, mc, 4'd0, 1'b1, junk(), 0, 0);
               push_wb(MTR);
            end else begin
               push(3'd3, mc | RET, 4'd0, 1'b1, junk(), 0, 0);
            end
         end
      endcase
   endtask

   // Called at a falling edge; leaves at a falling edge.
   task automatic run_queue(input int limit);
      exp_t e;
      for (int k = 0; k < limit && q.size() > 0; k++) begin
         e = q.pop_front();
         mem_ready = e.mr;
         instr     = e.opc;
         #1;
         check_val("state", 32'(state), 32'(e.st));
         check_val("ctrl", 32'(dut_ctrl), 32'(e.ctrl));
         check_val("aluop", 32'(ALUop), 32'(e.aop));
         check_val("instret", 32'(instret), 32'(exp_instret));
         check_val("illegal", 32'(illegal), 32'(e.ill));
         check_val("mem_timeout", 32'(mem_timeout), 32'(e.mto));
         if (e.ctrl[0]) exp_instret = exp_instret + 4'd1;
         @(negedge clk);
      end
      q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_ctrl"}, 32'(dut_ctrl), 32'h0);
      check_val({tag, "_aluop"}, 32'(ALUop), 32'h0);
      check_val({tag, "_state"}, 32'(state), 32'h0);
      check_val({tag, "_instret"}, 32'(instret), 32'h0);
      check_val({tag, "_flags"}, 32'({illegal, mem_timeout}), 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mem_ready = rbit();
      #1;
      check_all_zero("rst_hold");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_instret = 4'd0;
   endtask

   task automatic random_stream(input int n);
      int idx, fw, mw;
      for (int i = 0; i < n; i++) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
         idx = $urandom_range(0, 8);
`else
         idx = $urandom_range(0, 9);
`endif
         fw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
         mw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
         expand((idx == 9) ? OP_BAD : legal_ops[idx], fw, mw);
         run_queue(1000);
      end
   endtask

   initial begin
      legal_ops = '{OP_R, OP_LOAD, OP_STORE, OP_BR, OP_IMM, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC};
      exp_instret = 4'd0;
      rst = 1'b0;
      mem_ready = 1'b1;
      instr = OP_R;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // R-type stream with zero-wait memory: 0,1,2,4 per instruction
      for (int i = 0; i < 3; i++) expand(OP_R, 0, 0);
      run_queue(1000);
      check_val("instret_after_3R", 32'(instret), 32'd3);

      // LOAD with two MEM wait cycles, then BRANCH and STORE
      expand(OP_LOAD, 0, 2);
      expand(OP_BR, 0, 0);
      expand(OP_STORE, 0, 0);
      run_queue(1000);

      random_stream(60);

      // Asynchronous reset in the middle of a STORE's MEM wait
      expand(OP_STORE, 0, 5);
      run_queue(5);
      mem_ready = 1'b0;
      #1;
      check_val("mid_mem_memwrite", 32'(memwrite), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("mid_mem_rst");
      @(negedge clk);
      rst = 1'b1;
      exp_instret = 4'd0;

      // FETCH timeout, then MEM timeout
      expand(OP_R, 16, 0);
      run_queue(1000);
      do_reset();
      expand(OP_LOAD, 0, 16);
      run_queue(1000);
      do_reset();

      // Illegal opcode followed by normal traffic
      expand(OP_BAD, 0, 0);
      run_queue(1000);
`ifdef MCTRL_ILLEGAL_TRAP_EN
      do_reset();
`endif
      random_stream(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
